// File: rtl/lc3b_mem_arbiter_pkg.sv
// Shared types for the LC-3b memory arbiter: bus word types, arbiter states and requester ids.
package lc3b_mem_arbiter_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GNT_I,
        ARB_GNT_D
    } lc3b_arb_state;

    typedef enum logic {
        REQ_IMEM,
        REQ_DMEM
    } lc3b_requester;

    localparam int WD_WIDTH = 16;

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog: counts granted cycles without an acknowledge and flags expiry on the last allowed one.
module arb_watchdog
    import lc3b_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [WD_WIDTH-1:0] LAST_COUNT = WD_WIDTH'(TIMEOUT - 1);

    logic [WD_WIDTH-1:0] count_q;
    logic [WD_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = enable && (count_q == LAST_COUNT);

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// Shares one memory bus between fetch and data ports, with LDI/STI lock, flush abort and a watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise DMEM wins every tie.
module lc3b_mem_arbiter
    import lc3b_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_cyc,
    input  logic        imem_stb,
    input  logic [15:0] imem_addr,
    output logic [15:0] imem_rdata,
    output logic        imem_ack,
    output logic        imem_err,
    input  logic        dmem_cyc,
    input  logic        dmem_stb,
    input  logic        dmem_we,
    input  logic [1:0]  dmem_sel,
    input  logic [15:0] dmem_addr,
    input  logic [15:0] dmem_wdata,
    output logic [15:0] dmem_rdata,
    output logic        dmem_ack,
    output logic        dmem_err,
    output logic        mem_cyc,
    output logic        mem_stb,
    output logic        mem_we,
    output logic [1:0]  mem_sel,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        arb_timeout
);

    lc3b_arb_state state_q, state_d;
    lc3b_requester last_gnt_q, last_gnt_d;
    lc3b_requester lock_owner_q, lock_owner_d;
    logic          lock_q, lock_d;
    logic          timeout_q, timeout_d;

    logic          imem_req, dmem_req;
    logic          owner_cyc, owner_req;
    lc3b_requester tie_win;
    logic          wd_clear, wd_enable, wd_expire;

    assign imem_req  = imem_cyc & imem_stb;
    assign dmem_req  = dmem_cyc & dmem_stb;
    assign owner_cyc = (lock_owner_q == REQ_DMEM) ? dmem_cyc : imem_cyc;
    assign owner_req = (lock_owner_q == REQ_DMEM) ? dmem_req : imem_req;

`ifdef ARB_ROUND_ROBIN_EN
    assign tie_win = (last_gnt_q == REQ_IMEM) ? REQ_DMEM : REQ_IMEM;
`else
    assign tie_win = REQ_DMEM;
`endif

    // Watchdog only runs while the granted requester still holds its cycle and has no ack yet.
    assign wd_clear  = (state_q == ARB_IDLE);
    assign wd_enable = ((state_q == ARB_GNT_I) && imem_cyc && !mem_ack) ||
                       ((state_q == ARB_GNT_D) && dmem_cyc && !mem_ack);

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    always_comb begin
        state_d      = state_q;
        last_gnt_d   = last_gnt_q;
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        timeout_d    = timeout_q;
        mem_cyc      = 1'b0;
        mem_stb      = 1'b0;
        mem_we       = 1'b0;
        mem_sel      = 2'b00;
        mem_addr     = '0;
        mem_wdata    = '0;
        imem_rdata   = '0;
        imem_ack     = 1'b0;
        imem_err     = 1'b0;
        dmem_rdata   = '0;
        dmem_ack     = 1'b0;
        dmem_err     = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                // A locked owner re-requesting wins outright so LDI/STI stays atomic.
                if (lock_q && owner_req) begin
                    state_d    = (lock_owner_q == REQ_DMEM) ? ARB_GNT_D : ARB_GNT_I;
                    last_gnt_d = lock_owner_q;
                    lock_d     = 1'b0;
                end else if (imem_req && dmem_req) begin
                    state_d    = (tie_win == REQ_DMEM) ? ARB_GNT_D : ARB_GNT_I;
                    last_gnt_d = tie_win;
                    lock_d     = 1'b0;
                end else if (dmem_req) begin
                    state_d    = ARB_GNT_D;
                    last_gnt_d = REQ_DMEM;
                    lock_d     = 1'b0;
                end else if (imem_req) begin
                    state_d    = ARB_GNT_I;
                    last_gnt_d = REQ_IMEM;
                    lock_d     = 1'b0;
                end else if (lock_q && !owner_cyc) begin
                    lock_d = 1'b0;
                end
            end

            ARB_GNT_I: begin
                mem_cyc    = imem_cyc;
                mem_stb    = imem_cyc & imem_stb;
                mem_sel    = 2'b11;
                mem_addr   = imem_addr;
                imem_rdata = mem_rdata;
                if (!imem_cyc) begin
                    state_d = ARB_IDLE;
                end else if (mem_ack) begin
                    imem_ack     = 1'b1;
                    state_d      = ARB_IDLE;
                    lock_d       = 1'b1;
                    lock_owner_d = REQ_IMEM;
                end else if (wd_expire) begin
                    imem_err  = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ARB_IDLE;
                end
            end

            ARB_GNT_D: begin
                mem_cyc    = dmem_cyc;
                mem_stb    = dmem_cyc & dmem_stb;
                mem_we     = dmem_we;
                mem_sel    = dmem_sel;
                mem_addr   = dmem_addr;
                mem_wdata  = dmem_wdata;
                dmem_rdata = mem_rdata;
                if (!dmem_cyc) begin
                    state_d = ARB_IDLE;
                end else if (mem_ack) begin
                    dmem_ack     = 1'b1;
                    state_d      = ARB_IDLE;
                    lock_d       = 1'b1;
                    lock_owner_d = REQ_DMEM;
                end else if (wd_expire) begin
                    dmem_err  = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ARB_IDLE;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            last_gnt_q   <= REQ_IMEM;
            lock_q       <= 1'b0;
            lock_owner_q <= REQ_IMEM;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_gnt_q   <= last_gnt_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            timeout_q    <= timeout_d;
        end
    end

    assign arb_timeout = timeout_q;

endmodule
